aig_sweep_equiv_ctrl: RTL

//  Sequencer that runs an exhaustive input sweep through two combinational benchmark netlists (N_IN inputs, N_OUT outputs).

---
 rtl/aig_sweep_pkg.sv | 21 ++
 rtl/aig_sweep_misr.sv | 31 +++
 rtl/aig_sweep_equiv_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/aig_sweep_pkg.sv
// rtl/aig_sweep_pkg.sv - shared types and MISR constants for the sweep equivalence sequencer
// Configuration macro used by the bundle: AIG_SWEEP_MISR_EN
package aig_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int              MISR_W    = 16;
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;
    localparam logic [MISR_W-1:0] MISR_SEED = 16'hFFFF;

    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                   input logic [MISR_W-1:0] din);
        return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0) ^ din;
    endfunction

endpackage

// File: rtl/aig_sweep_misr.sv
// rtl/aig_sweep_misr.sv - 16-bit MISR compacting golden netlist outputs
// Instantiated only when AIG_SWEEP_MISR_EN is defined
module aig_sweep_misr
    import aig_sweep_pkg::*;
#(
    parameter int N_OUT = 6
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [N_OUT-1:0]  din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] r_sig;
    logic [MISR_W-1:0] w_din;

    assign w_din = MISR_W'(din);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_sig <= MISR_SEED;
        end else if (step) begin
            r_sig <= misr_next(r_sig, w_din);
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/aig_sweep_equiv_ctrl.sv
// rtl/aig_sweep_equiv_ctrl.sv - exhaustive input sweep comparing two netlists' outputs
// Optional output signature MISR: AIG_SWEEP_MISR_EN
module aig_sweep_equiv_ctrl
    import aig_sweep_pkg::*;
#(
    parameter int N_IN             = 9,
    parameter int N_OUT            = 6,
    parameter int SETTLE_CYCLES    = 1,
    parameter int STOP_ON_MISMATCH = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   vec_o,
    input  logic [N_OUT-1:0]  f_a_i,
    input  logic [N_OUT-1:0]  f_b_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     mismatch_cnt,
    output logic              first_fail_vld,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic [MISR_W-1:0] signature
);

    localparam int         CNT_W         = N_IN + 1;
    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t            r_state;
    logic [N_IN-1:0]   r_vec;
    logic [3:0]        r_settle;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [N_IN:0]     r_cnt;
    logic              r_ff_vld;
    logic [N_IN-1:0]   r_ff_vec;

    logic              w_start_ok;
    logic              w_mis;
    logic              w_stop;
    logic [N_IN:0]     w_cnt_sample;

    assign w_start_ok   = start && !abort;
    assign w_mis        = (f_a_i != f_b_i);
    assign w_stop       = (&r_vec) || ((STOP_ON_MISMATCH != 0) && w_mis);
    // Count including the vector being sampled, so pass reflects the final SAMPLE too
    assign w_cnt_sample = r_cnt + CNT_W'(w_mis);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_vec    <= '0;
            r_settle <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_cnt    <= '0;
            r_ff_vld <= 1'b0;
            r_ff_vec <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state  <= ST_SETTLE;
                        r_vec    <= '0;
                        r_cnt    <= '0;
                        r_ff_vld <= 1'b0;
                        r_pass   <= 1'b0;
                        r_settle <= SETTLE_RELOAD;
                        r_busy   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_settle == 4'd0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_sample;
                        if (w_mis && !r_ff_vld) begin
                            r_ff_vld <= 1'b1;
                            r_ff_vec <= r_vec;
                        end
                        if (w_stop) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_cnt_sample == '0);
                        end else begin
                            r_state  <= ST_SETTLE;
                            r_vec    <= r_vec + N_IN'(1);
                            r_settle <= SETTLE_RELOAD;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign vec_o          = r_vec;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign mismatch_cnt   = r_cnt;
    assign first_fail_vld = r_ff_vld;
    assign first_fail_vec = r_ff_vec;

`ifdef AIG_SWEEP_MISR_EN
    logic w_misr_load;
    logic w_misr_step;

    assign w_misr_load = (r_state == ST_IDLE) && w_start_ok;
    assign w_misr_step = (r_state == ST_SAMPLE) && !abort;

    aig_sweep_misr #(
        .N_OUT (N_OUT)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (w_misr_load),
        .step (w_misr_step),
        .din  (f_a_i),
        .sig  (signature)
    );
`else
    assign signature = '0;
`endif

endmodule
